// File: rtl/receive_checker_pkg.sv
// receive_checker_pkg: shared widths, FSM encoding and sequence increment for the receive checker.
package receive_checker_pkg;
    localparam int WORD_W = 10;
    localparam int DATA_W = 9;
    localparam logic [DATA_W-1:0] SEQ_INC = 9'd1;
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/receive_checker_parity_seq_check.sv
// parity_seq_check: combinational parity and count-sequence check of one channel word.
module parity_seq_check
    import receive_checker_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_prev,
    input  logic              i_prev_valid,
    output logic              o_parity_err,
    output logic              o_seq_err
);
    logic [DATA_W-1:0] w_count;
    logic [DATA_W-1:0] w_next;
    assign w_count      = i_word[DATA_W-1:0];
    // 9-bit addition wraps 511 to 0, which is a legal step
    assign w_next       = i_prev + SEQ_INC;
    assign o_parity_err = ^i_word;
    assign o_seq_err    = i_prev_valid && (w_count != i_prev) && (w_count != w_next);
endmodule

// File: rtl/receive_checker.sv
// receive_checker: two-stage receive checker with HUNT/LOCKED lock tracking and saturating error count.
// Optional sticky_err output enabled by RECEIVE_CHECKER_STICKY_EN.
module receive_checker
    import receive_checker_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic [WORD_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              seq_err,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count
`ifdef RECEIVE_CHECKER_STICKY_EN
    ,
    output logic              sticky_err
`endif
);
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    logic [WORD_W-1:0] r_word;
    logic              r_word_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_prev_valid;
    logic              r_valid;
    logic              r_perr;
    logic              r_serr;
    logic [ERR_W-1:0]  r_err_count;
    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_good_run;
    logic [3:0]        r_bad_run;
    logic [3:0]        w_good_nx;
    logic [3:0]        w_bad_nx;
    logic              w_perr;
    logic              w_serr;
    logic              w_bad;

    // r_data doubles as the stored previous count
    parity_seq_check u_check (
        .i_word       (r_word),
        .i_prev       (r_data),
        .i_prev_valid (r_prev_valid),
        .o_parity_err (w_perr),
        .o_seq_err    (w_serr)
    );

    assign w_bad = w_perr | w_serr;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_word       <= '0;
            r_word_vld   <= 1'b0;
            r_data       <= '0;
            r_prev_valid <= 1'b0;
            r_valid      <= 1'b0;
            r_perr       <= 1'b0;
            r_serr       <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_word_vld <= enable;
            if (enable) r_word <= data_in;
            r_valid <= r_word_vld;
            if (r_word_vld) begin
                r_data       <= r_word[DATA_W-1:0];
                r_prev_valid <= 1'b1;
                r_perr       <= w_perr;
                r_serr       <= w_serr;
                if (w_bad && r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= ST_HUNT;
            r_good_run <= '0;
            r_bad_run  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_good_run <= w_good_nx;
            r_bad_run  <= w_bad_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_good_nx  = r_good_run;
        w_bad_nx   = r_bad_run;
        if (r_word_vld) begin
            if (r_state == ST_HUNT) begin
                w_good_nx = w_bad ? 4'd0 : r_good_run + 4'd1;
                if (!w_bad && (r_good_run + 4'd1 == LOCK_C)) begin
                    w_state_nx = ST_LOCKED;
                    w_good_nx  = 4'd0;
                end
            end else begin
                w_bad_nx = w_bad ? r_bad_run + 4'd1 : 4'd0;
                if (w_bad && (r_bad_run + 4'd1 == LOSS_C)) begin
                    w_state_nx = ST_HUNT;
                    w_bad_nx   = 4'd0;
                end
            end
        end
    end

`ifdef RECEIVE_CHECKER_STICKY_EN
    logic r_sticky;
    always_ff @(posedge clk or posedge clear) begin
        if (clear) r_sticky <= 1'b0;
        else if (r_word_vld && w_bad) r_sticky <= 1'b1;
    end
    assign sticky_err = r_sticky;
`endif

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign seq_err    = r_serr;
    assign locked     = (r_state == ST_LOCKED);
    assign err_count  = r_err_count;
endmodule
